stereo_pair_serializer: RTL and testbench

- Serializes a stereo sample pair (L, R) into a single tagged mono stream: L beat (dir=0), then R beat (dir=1).
- Transmit-side counterpart of the stereo demux. Sits between the stereo processing chain and the single-lane sample transport or DAC interface.
- Holds one active pair plus one pending pair, uses a valid/ready output handshake, and enforces optional inter-beat pacing.

---
 rtl/stereo_pair_serializer.sv | 203 ++++++++++++++++++++
 tb/tb_stereo_pair_serializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stereo_pair_serializer.sv
`default_nettype none
// ============================================================================
// Module   : stereo_pair_serializer
// Purpose  : Serializes (L,R) pairs into a tagged mono valid/ready stream with
//            a one-pair pending buffer and optional inter-beat gap.
//            Optional mono down-mix beat enabled by macro SER_MONO_MIX_EN.
// Revision : 1.0
// ============================================================================
module stereo_pair_serializer #(
    parameter int WIDTH      = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] left_sample,
    input  logic [WIDTH-1:0] right_sample,
    input  logic             pair_valid,
`ifdef SER_MONO_MIX_EN
    input  logic             mono_mode,
`endif
    output logic [WIDTH-1:0] sample_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             dir_out,
    output logic             busy,
    output logic             overflow,
    input  logic             clear_ovf
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EMIT_L = 3'd1,
        ST_GAP_L  = 3'd2,
        ST_EMIT_R = 3'd3,
        ST_GAP_R  = 3'd4
    } state_t;

    logic mono_in;
`ifdef SER_MONO_MIX_EN
    assign mono_in = mono_mode;
`else
    assign mono_in = 1'b0;
`endif

    state_t           state_q, state_d;
    logic             act_occ_q, act_occ_d, pend_occ_q, pend_occ_d;
    logic             act_mono_q, act_mono_d, pend_mono_q, pend_mono_d;
    logic [WIDTH-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
    logic [WIDTH-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] sample_out_q, sample_out_d;
    logic             valid_out_q, valid_out_d;
    logic             dir_out_q, dir_out_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;

    logic             accept, slot_done, act_free;
    logic [WIDTH:0]   mix_sum;

    always_comb begin
        state_d      = state_q;
        act_occ_d    = act_occ_q;
        act_mono_d   = act_mono_q;
        act_l_d      = act_l_q;
        act_r_d      = act_r_q;
        pend_occ_d   = pend_occ_q;
        pend_mono_d  = pend_mono_q;
        pend_l_d     = pend_l_q;
        pend_r_d     = pend_r_q;
        gap_cnt_d    = gap_cnt_q;
        sample_out_d = sample_out_q;
        overflow_d   = overflow_q & ~clear_ovf;
        mix_sum      = '0;

        accept    = valid_out_q && ready_in;
        slot_done = accept && ((state_q == ST_EMIT_R) ||
                               ((state_q == ST_EMIT_L) && act_mono_q));
        act_free  = !act_occ_q || slot_done;

        // Slot bookkeeping: free on final beat, promote pending, then place new pair.
        if (slot_done) begin
            act_occ_d = 1'b0;
        end
        if (act_free && pend_occ_q) begin
            act_occ_d  = 1'b1;
            act_mono_d = pend_mono_q;
            act_l_d    = pend_l_q;
            act_r_d    = pend_r_q;
            pend_occ_d = 1'b0;
        end
        if (pair_valid) begin
            if (!act_occ_d && ((state_q == ST_IDLE) || slot_done)) begin
                act_occ_d  = 1'b1;
                act_mono_d = mono_in;
                act_l_d    = left_sample;
                act_r_d    = right_sample;
            end else if (!pend_occ_d) begin
                pend_occ_d  = 1'b1;
                pend_mono_d = mono_in;
                pend_l_d    = left_sample;
                pend_r_d    = right_sample;
            end else begin
                overflow_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (act_occ_q) state_d = ST_EMIT_L;
            end
            ST_EMIT_L: begin
                if (accept) begin
                    if (GAP_CYCLES > 0) begin
                        state_d   = act_mono_q ? ST_GAP_R : ST_GAP_L;
                        gap_cnt_d = GAP_LOAD;
                    end else if (act_mono_q) begin
                        state_d = act_occ_d ? ST_EMIT_L : ST_IDLE;
                    end else begin
                        state_d = ST_EMIT_R;
                    end
                end
            end
            ST_GAP_L: begin
                if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - GAP_ONE;
                if (gap_cnt_q <= GAP_ONE) state_d = ST_EMIT_R;
            end
            ST_EMIT_R: begin
                if (accept) begin
                    if (GAP_CYCLES > 0) begin
                        state_d   = ST_GAP_R;
                        gap_cnt_d = GAP_LOAD;
                    end else begin
                        state_d = act_occ_d ? ST_EMIT_L : ST_IDLE;
                    end
                end
            end
            ST_GAP_R: begin
                if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - GAP_ONE;
                if (gap_cnt_q <= GAP_ONE) state_d = act_occ_d ? ST_EMIT_L : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state and next slot contents.
        valid_out_d = (state_d == ST_EMIT_L) || (state_d == ST_EMIT_R);
        dir_out_d   = (state_d == ST_EMIT_R);
        if (state_d == ST_EMIT_L) begin
            mix_sum      = {act_l_d[WIDTH-1], act_l_d} + {act_r_d[WIDTH-1], act_r_d};
            sample_out_d = act_mono_d ? mix_sum[WIDTH:1] : act_l_d;
        end else if (state_d == ST_EMIT_R) begin
            sample_out_d = act_r_d;
        end
        busy_d = act_occ_d || pend_occ_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            act_occ_q    <= 1'b0;
            act_mono_q   <= 1'b0;
            act_l_q      <= '0;
            act_r_q      <= '0;
            pend_occ_q   <= 1'b0;
            pend_mono_q  <= 1'b0;
            pend_l_q     <= '0;
            pend_r_q     <= '0;
            gap_cnt_q    <= '0;
            sample_out_q <= '0;
            valid_out_q  <= 1'b0;
            dir_out_q    <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_occ_q    <= act_occ_d;
            act_mono_q   <= act_mono_d;
            act_l_q      <= act_l_d;
            act_r_q      <= act_r_d;
            pend_occ_q   <= pend_occ_d;
            pend_mono_q  <= pend_mono_d;
            pend_l_q     <= pend_l_d;
            pend_r_q     <= pend_r_d;
            gap_cnt_q    <= gap_cnt_d;
            sample_out_q <= sample_out_d;
            valid_out_q  <= valid_out_d;
            dir_out_q    <= dir_out_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
        end
    end

    assign sample_out = sample_out_q;
    assign valid_out  = valid_out_q;
    assign dir_out    = dir_out_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_stereo_pair_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stereo_pair_serializer
// Purpose  : Scoreboard bench for stereo_pair_serializer (GAP=0 and GAP=3).
// Revision : 1.0
// ============================================================================
module tb_stereo_pair_serializer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] left_sample, right_sample, sample_out;
    logic        pair_valid, valid_out, ready_in, dir_out, busy, overflow, clear_ovf;
    logic [15:0] g_left, g_right, g_sample;
    logic        g_pv, g_valid, g_ready, g_dir, g_busy, g_ovf;
`ifdef SER_MONO_MIX_EN
    logic        mono_mode;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int g_last = -1;
    int g_beats = 0;
    logic [16:0] sb_q[$];
    logic [16:0] sbg_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stereo_pair_serializer #(.WIDTH(16), .GAP_CYCLES(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .left_sample(left_sample), .right_sample(right_sample), .pair_valid(pair_valid),
`ifdef SER_MONO_MIX_EN
        .mono_mode(mono_mode),
`endif
        .sample_out(sample_out), .valid_out(valid_out), .ready_in(ready_in),
        .dir_out(dir_out), .busy(busy), .overflow(overflow), .clear_ovf(clear_ovf)
    );

    stereo_pair_serializer #(.WIDTH(16), .GAP_CYCLES(3)) dut_gap (
        .clk(clk), .reset_n(reset_n),
        .left_sample(g_left), .right_sample(g_right), .pair_valid(g_pv),
`ifdef SER_MONO_MIX_EN
        .mono_mode(1'b0),
`endif
        .sample_out(g_sample), .valid_out(g_valid), .ready_in(g_ready),
        .dir_out(g_dir), .busy(g_busy), .overflow(g_ovf), .clear_ovf(1'b0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: compare every transferred beat against the queue head.
    always @(negedge clk) begin
        if (reset_n && valid_out && ready_in) begin
            if (sb_q.size() == 0) check("unexpected_beat", {15'd0, dir_out, sample_out}, 32'hDEAD);
            else check("beat", {15'd0, dir_out, sample_out}, {15'd0, sb_q.pop_front()});
        end
        if (reset_n && g_valid && g_ready) begin
            if (sbg_q.size() == 0) check("gap_unexpected_beat", {15'd0, g_dir, g_sample}, 32'hDEAD);
            else check("gap_beat", {15'd0, g_dir, g_sample}, {15'd0, sbg_q.pop_front()});
            if (g_last >= 0) check("gap_spacing", cyc - g_last, 4);
            g_last = cyc;
            g_beats++;
        end
    end

    task automatic send_pair(input logic [15:0] l, input logic [15:0] r, input bit push);
        left_sample = l; right_sample = r; pair_valid = 1'b1;
        if (push) begin
            sb_q.push_back({1'b0, l});
            sb_q.push_back({1'b1, r});
        end
        @(posedge clk); #1;
        pair_valid = 1'b0;
    endtask

    task automatic send_pair_g(input logic [15:0] l, input logic [15:0] r);
        g_left = l; g_right = r; g_pv = 1'b1;
        sbg_q.push_back({1'b0, l});
        sbg_q.push_back({1'b1, r});
        @(posedge clk); #1;
        g_pv = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || busy || valid_out) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, {31'd0, n < 60}, 1);
    endtask

    initial begin
        reset_n = 1'b0; pair_valid = 1'b0; ready_in = 1'b1; clear_ovf = 1'b0;
        left_sample = '0; right_sample = '0;
        g_pv = 1'b0; g_ready = 1'b1; g_left = '0; g_right = '0;
`ifdef SER_MONO_MIX_EN
        mono_mode = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {13'd0, valid_out, dir_out, busy, sample_out}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic latency: L at N+1, R at N+2, idle at N+3.
        send_pair(16'h1234, 16'hFFFB, 1'b1);
        check("lat_n0_valid", {31'd0, valid_out}, 0);
        @(posedge clk); #1;
        check("lat_n1_L", {14'd0, valid_out, dir_out, sample_out}, {14'd0, 2'b10, 16'h1234});
        @(posedge clk); #1;
        check("lat_n2_R", {14'd0, valid_out, dir_out, sample_out}, {14'd0, 2'b11, 16'hFFFB});
        @(posedge clk); #1;
        check("lat_n3_idle", {30'd0, valid_out, busy}, 0);

        // Back-pressure on the L beat.
        ready_in = 1'b0;
        send_pair(16'h1234, 16'h0042, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check("stall_hold", {14'd0, valid_out, dir_out, sample_out}, {14'd0, 2'b10, 16'h1234});
            @(posedge clk); #1;
        end
        ready_in = 1'b1;
        @(posedge clk); #1;
        check("stall_R_next", {14'd0, valid_out, dir_out, sample_out}, {14'd0, 2'b11, 16'h0042});
        wait_drain("drain_stall");

        // Overflow: third pair dropped, stored pairs drain in order.
        ready_in = 1'b0;
        send_pair(16'h1111, 16'h2222, 1'b1);
        send_pair(16'h3333, 16'h4444, 1'b1);
        send_pair(16'h5555, 16'h6666, 1'b0);
        check("ovf_set", {30'd0, overflow, busy}, 32'd3);
        ready_in = 1'b1;
        wait_drain("drain_ovf");
        check("ovf_sticky", {31'd0, overflow}, 1);
        clear_ovf = 1'b1;
        @(posedge clk); #1;
        clear_ovf = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 0);

`ifdef SER_MONO_MIX_EN
        // Mono down-mix: (100 + -301) >>> 1 = -101.
        mono_mode = 1'b1;
        sb_q.push_back({1'b0, 16'hFF9B});
        send_pair(16'd100, 16'hFED3, 1'b0);
        mono_mode = 1'b0;
        send_pair(16'h0007, 16'h0008, 1'b1);
        wait_drain("drain_mono");
`endif

        // Gap pacing on the GAP_CYCLES=3 instance.
        send_pair_g(16'h0A0A, 16'h0B0B);
        send_pair_g(16'h0C0C, 16'h0D0D);
        begin
            int n = 0;
            while ((sbg_q.size() != 0 || g_busy || g_valid) && n < 80) begin
                @(posedge clk); #1;
                n++;
            end
            check("gap_drain", {31'd0, n < 80}, 1);
        end
        check("gap_beat_count", g_beats, 4);

        // Reset in EMIT_R with the pending slot occupied.
        ready_in = 1'b0;
        send_pair(16'h7777, 16'h8888, 1'b1);
        send_pair(16'h9999, 16'hAAAA, 1'b1);
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
        check("pre_rst_emit_R", {14'd0, valid_out, dir_out, sample_out}, {14'd0, 2'b11, 16'h8888});
        reset_n = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        check("rst_mid_valid_busy", {30'd0, valid_out, busy}, 0);
        reset_n = 1'b1;
        ready_in = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_quiet", {30'd0, valid_out, busy}, 0);

        check("sb_empty", sb_q.size() + sbg_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
